// File: rtl/gpio_peripheral_if.sv
// Bus-side signals between the memory-map decoder (device slot 2) and the GPIO slave.
// The slave returns rdata combinationally in the same cycle as sel/addr.
interface gpio_peripheral_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  sel;
  logic                  mem_write;
  logic [DATA_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] wdata;
  logic [DATA_WIDTH-1:0] rdata;

  modport master (
    output sel,
    output mem_write,
    output addr,
    output wdata,
    input  rdata
  );

  modport slave (
    input  sel,
    input  mem_write,
    input  addr,
    input  wdata,
    output rdata
  );
endinterface

// File: rtl/gpio_peripheral.sv
// Memory-mapped GPIO slave: registered output pins, synchronised and debounced inputs,
// sticky rising-edge flags with write-1-to-clear, and a level interrupt.
module gpio_peripheral #(
  parameter int DATA_WIDTH      = 32,
  parameter int OUT_WIDTH       = 8,
  parameter int IN_WIDTH        = 8,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  gpio_peripheral_if.slave     bus,
  input  logic [IN_WIDTH-1:0]  gpio_in,
  output logic [OUT_WIDTH-1:0] gpio_out,
  output logic                 irq
);

  localparam int                CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [DATA_WIDTH-1:0] ADDR_OUT = DATA_WIDTH'(0);
  localparam logic [DATA_WIDTH-1:0] ADDR_IN  = DATA_WIDTH'(1);

  logic [OUT_WIDTH-1:0]            r_out;
  logic [IN_WIDTH-1:0]             r_sync1;
  logic [IN_WIDTH-1:0]             r_sync2;
  logic [IN_WIDTH-1:0]             r_stable;
  logic [IN_WIDTH-1:0]             r_flags;
  logic [IN_WIDTH-1:0][CNT_W-1:0]  r_cnt;

  logic                            w_wr_en;
  logic                            w_wr_out;
  logic                            w_wr_flag;
  logic [IN_WIDTH-1:0]             w_clr;
  logic [IN_WIDTH-1:0]             w_stable_next;
  logic [IN_WIDTH-1:0]             w_rise;
  logic [IN_WIDTH-1:0][CNT_W-1:0]  w_cnt_next;
  logic [IN_WIDTH-1:0]             w_flags_next;

  assign w_wr_en   = bus.sel & bus.mem_write;
  assign w_wr_out  = w_wr_en & (bus.addr == ADDR_OUT);
  assign w_wr_flag = w_wr_en & (bus.addr == ADDR_IN);
  assign w_clr     = w_wr_flag ? bus.wdata[16 +: IN_WIDTH] : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out <= '0;
    end else if (w_wr_out) begin
      r_out <= bus.wdata[OUT_WIDTH-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= gpio_in;
      r_sync2 <= r_sync1;
    end
  end

  // Per-bit debounce: count consecutive clocks where the synced pin disagrees with the
  // accepted level; any agreement restarts the count, so short glitches never land.
  genvar gi;
  generate
    for (gi = 0; gi < IN_WIDTH; gi++) begin : g_bit
      logic w_differs;
      logic w_accept;

      assign w_differs = r_sync2[gi] != r_stable[gi];
      assign w_accept  = w_differs && (r_cnt[gi] == CNT_LAST);

      assign w_cnt_next[gi]    = (!w_differs || w_accept) ? '0 : r_cnt[gi] + CNT_W'(1);
      assign w_stable_next[gi] = w_accept ? r_sync2[gi] : r_stable[gi];
      assign w_rise[gi]        = w_accept & r_sync2[gi];

      // A new edge outranks a simultaneous clear so no event is lost.
      assign w_flags_next[gi]  = (r_flags[gi] & ~w_clr[gi]) | w_rise[gi];
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt    <= '0;
      r_stable <= '0;
      r_flags  <= '0;
    end else begin
      r_cnt    <= w_cnt_next;
      r_stable <= w_stable_next;
      r_flags  <= w_flags_next;
    end
  end

  always_comb begin
    bus.rdata = '0;
    if (bus.addr == ADDR_OUT) begin
      bus.rdata[OUT_WIDTH-1:0] = r_out;
    end else if (bus.addr == ADDR_IN) begin
      bus.rdata[IN_WIDTH-1:0]  = r_stable;
      bus.rdata[16 +: IN_WIDTH] = r_flags;
    end
  end

  assign gpio_out = r_out;
  assign irq      = |r_flags;

endmodule

// File: tb/tb_gpio_peripheral.sv
// Scoreboard bench for gpio_peripheral: directed scenarios followed by random traffic,
// checked against a sliding-window behavioural model of sync + debounce + flags.
module tb_gpio_peripheral;
  localparam int DW = 32;
  localparam int OW = 8;
  localparam int IW = 8;
  localparam int DC = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [IW-1:0] gpio_in;
  logic [OW-1:0] gpio_out;
  logic          irq;

  gpio_peripheral_if #(.DATA_WIDTH(DW)) bus ();

  gpio_peripheral #(
    .DATA_WIDTH(DW), .OUT_WIDTH(OW), .IN_WIDTH(IW), .DEBOUNCE_CYCLES(DC)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus),
    .gpio_in(gpio_in), .gpio_out(gpio_out), .irq(irq)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] rdata;
    logic [7:0]  gout;
    logic        irq;
  } exp_t;

  exp_t exp_q[$];
  int vectors = 0;
  int miscompares = 0;

  // Reference model: pins reach the debouncer two samples late; a level is accepted once
  // the last DC delayed samples all disagree with the currently accepted level.
  logic [IW-1:0] m_p1 = '0, m_p2 = '0, m_stable = '0, m_flags = '0;
  logic [OW-1:0] m_out = '0;
  logic [IW-1:0] m_hist[$];

  task automatic model_clear();
    m_p1 = '0; m_p2 = '0; m_stable = '0; m_flags = '0; m_out = '0;
    m_hist.delete();
  endtask

  task automatic model_step();
    logic          wr_en;
    logic [IW-1:0] nst, rise, clr;
    bit            all_diff;
    wr_en = bus.sel && bus.mem_write;
    m_hist.push_back(m_p2);
    if (m_hist.size() > DC) void'(m_hist.pop_front());
    nst = m_stable;
    if (m_hist.size() == DC) begin
      for (int b = 0; b < IW; b++) begin
        all_diff = 1'b1;
        foreach (m_hist[k]) if (m_hist[k][b] == m_stable[b]) all_diff = 1'b0;
        if (all_diff) nst[b] = ~m_stable[b];
      end
    end
    rise = nst & ~m_stable;
    clr = (wr_en && bus.addr == 32'd1) ? bus.wdata[23:16] : '0;
    m_flags = (m_flags & ~clr) | rise;
    if (wr_en && bus.addr == 32'd0) m_out = bus.wdata[7:0];
    m_stable = nst;
    m_p2 = m_p1;
    m_p1 = gpio_in;
  endtask

  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_clear();
      else        model_step();
    end
  end

  function automatic logic [31:0] exp_rd(input logic [31:0] a);
    if (a == 32'd0) return {24'h0, m_out};
    if (a == 32'd1) return {8'h0, m_flags, 8'h0, m_stable};
    return 32'h0;
  endfunction

  task automatic rd(input logic [31:0] a);
    exp_t e;
    @(negedge clk);
    bus.sel = 1'b1; bus.mem_write = 1'b0; bus.addr = a; bus.wdata = $urandom;
    e.addr = a; e.rdata = exp_rd(a); e.gout = m_out; e.irq = |m_flags;
    exp_q.push_back(e);
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic s);
    @(negedge clk);
    bus.sel = s; bus.mem_write = 1'b1; bus.addr = a; bus.wdata = d;
  endtask

  task automatic idle();
    @(negedge clk);
    bus.sel = 1'b0; bus.mem_write = 1'b0;
  endtask

  task automatic rd_n(input logic [31:0] a, input int n);
    for (int i = 0; i < n; i++) rd(a);
  endtask

  // Monitor: every read cycle is a DUT response; pop and compare.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (bus.sel === 1'b1 && bus.mem_write === 1'b0) begin
        if (exp_q.size() == 0) begin
          vectors++; miscompares++;
          $display("FAIL unexpected_read addr=%h rdata=%h required=no read", bus.addr, bus.rdata);
        end else begin
          e = exp_q.pop_front();
          vectors++;
          if (bus.rdata !== e.rdata) begin
            miscompares++;
            $display("FAIL rdata t=%0t addr=%h got=%h required=%h", $time, e.addr, bus.rdata, e.rdata);
          end
          vectors++;
          if (gpio_out !== e.gout) begin
            miscompares++;
            $display("FAIL gpio_out t=%0t got=%h required=%h", $time, gpio_out, e.gout);
          end
          vectors++;
          if (irq !== e.irq) begin
            miscompares++;
            $display("FAIL irq t=%0t got=%b required=%b", $time, irq, e.irq);
          end
          $display("read t=%0t addr=%h rdata=%h gpio_out=%h irq=%b", $time, e.addr, bus.rdata, gpio_out, irq);
        end
      end
    end
  end

  initial begin
    int r, idx;
    logic [31:0] a;
    bus.sel = 1'b0; bus.mem_write = 1'b0; bus.addr = '0; bus.wdata = '0;
    gpio_in = 8'hFF;

    // reset with all pins high
    rd(1); rd(0);
    idle(); gpio_in = 8'h00; rst_n = 1'b1;
    rd_n(1, 3);

    // OUT register, and the same write with sel low
    wr(0, 32'hDEAD_BEA5, 1'b1);
    rd(0);
    wr(0, 32'h1234_5678, 1'b0);
    rd(0);

    // debounce accept on bit 0
    rd(1); gpio_in[0] = 1'b1;
    rd_n(1, 8);

    // glitch of 3 clocks on bit 1
    rd(1); gpio_in[1] = 1'b1;
    rd_n(1, 2);
    rd(1); gpio_in[1] = 1'b0;
    rd_n(1, 8);

    // W1C, then W1C landing on the edge a new rise qualifies
    wr(1, 32'h0001_0000, 1'b1);
    rd_n(1, 2);
    rd(1); gpio_in[0] = 1'b0;
    rd_n(1, 8);
    rd(1); gpio_in[0] = 1'b1;
    rd_n(1, 4);
    wr(1, 32'h0001_0000, 1'b1);
    rd_n(1, 3);

    // reset in the middle of a debounce
    wr(1, 32'h00FF_0000, 1'b1);
    rd(1); gpio_in[0] = 1'b0;
    rd_n(1, 8);
    rd(1); gpio_in[0] = 1'b1;
    rd_n(1, 2);
    idle(); rst_n = 1'b0;
    rd(1); rd(0);
    idle(); rst_n = 1'b1;
    rd_n(1, 8);

    // unmapped address: read zero, write has no effect
    wr(0, 32'h0000_005A, 1'b1);
    wr(2, 32'hFFFF_FFFF, 1'b1);
    rd(2); rd(0); rd(1);

    // random traffic
    for (int n = 0; n < 3000; n++) begin
      r = $urandom_range(0, 99);
      if (r < 50) begin
        idx = $urandom_range(0, 9);
        if (idx < 4)      a = 32'd0;
        else if (idx < 8) a = 32'd1;
        else if (idx < 9) a = 32'd2;
        else              a = $urandom;
        rd(a);
      end else if (r < 70) wr(0, $urandom, 1'b1);
      else if (r < 82)     wr(1, $urandom, 1'b1);
      else if (r < 90)     wr($urandom_range(0, 1), $urandom, 1'b0);
      else                 wr(32'd2 + $urandom_range(0, 5), $urandom, 1'b1);
      if ($urandom_range(0, 5) == 0) begin
        idx = $urandom_range(0, IW - 1);
        gpio_in[idx] = ~gpio_in[idx];
      end
    end

    idle(); idle(); idle();
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL pending_reads got=%0d required=0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
